// File: rtl/core_scheduler.sv
// core_scheduler: per-core sequencer stepping a block through fetch/decode/mem/execute/update until RET.
module core_scheduler #(
  parameter int THREADS_PER_BLOCK = 4
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 start,
  input  logic [$clog2(THREADS_PER_BLOCK):0]   thread_count,
  input  logic                                 instr_valid,
  input  logic                                 decoded_ret,
  input  logic [THREADS_PER_BLOCK-1:0]         lsu_busy,
  input  logic [7:0]                           next_pc,
  output logic                                 instr_req,
  output logic [2:0]                           core_state,
  output logic [7:0]                           current_pc,
  output logic                                 done
);
  localparam int CW = $clog2(THREADS_PER_BLOCK) + 1;
  typedef enum logic [2:0] {
    S_IDLE    = 3'b000,
    S_FETCH   = 3'b001,
    S_DECODE  = 3'b010,
    S_REQUEST = 3'b011,
    S_WAIT    = 3'b100,
    S_EXECUTE = 3'b101,
    S_UPDATE  = 3'b110,
    S_DONE    = 3'b111
  } state_t;
  state_t state;
  logic [CW-1:0] count;
  logic [THREADS_PER_BLOCK-1:0] mask;
  // Busy flags from threads beyond the latched count must not stall WAIT.
  for (genvar i = 0; i < THREADS_PER_BLOCK; i++) begin : g_mask
    assign mask[i] = count > CW'(i);
  end
  assign instr_req  = state == S_FETCH;
  assign core_state = state;
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      current_pc <= 8'h00;
      done       <= 1'b0;
      count      <= '0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          count <= thread_count;
          state <= thread_count == '0 ? S_DONE : S_FETCH;
          done  <= thread_count == '0;
        end
        S_FETCH:   state <= instr_valid ? S_DECODE : S_FETCH;
        S_DECODE:  state <= S_REQUEST;
        S_REQUEST: state <= S_WAIT;
        S_WAIT:    state <= |(lsu_busy & mask) ? S_WAIT : S_EXECUTE;
        S_EXECUTE: state <= S_UPDATE;
        S_UPDATE: if (decoded_ret) begin
          done  <= 1'b1;
          state <= S_DONE;
        end else begin
          current_pc <= next_pc;
          state      <= S_FETCH;
        end
        S_DONE:    state <= S_DONE;
      endcase
    end
  end
endmodule

// File: tb/tb_core_scheduler.sv
// tb_core_scheduler: vector table plus hand sequences; expected outputs queued at drive time, checked after the edge.
module tb_core_scheduler;
  logic       clk = 1'b0;
  logic       reset, start, instr_valid, decoded_ret;
  logic [2:0] thread_count;
  logic [3:0] lsu_busy;
  logic [7:0] next_pc;
  logic       instr_req, done;
  logic [2:0] core_state;
  logic [7:0] current_pc;
  int tests = 0;
  int fails = 0;
  typedef struct packed {
    logic [2:0] st;
    logic [7:0] pc;
    logic       dn;
    logic       rq;
  } exp_t;
  typedef struct {
    logic       r, s;
    logic [2:0] tc;
    logic       iv, rt;
    logic [3:0] b;
    logic [7:0] np;
    logic [2:0] es;
    logic [7:0] ep;
    logic       ed;
  } vec_t;
  exp_t  q[$];
  string nq[$];
  vec_t  tbl[28];
  core_scheduler #(.THREADS_PER_BLOCK(4)) dut (
    .clk(clk), .reset(reset), .start(start), .thread_count(thread_count),
    .instr_valid(instr_valid), .decoded_ret(decoded_ret), .lsu_busy(lsu_busy),
    .next_pc(next_pc), .instr_req(instr_req), .core_state(core_state),
    .current_pc(current_pc), .done(done)
  );
  always #5 clk = ~clk;
  task automatic check();
    exp_t  e;
    string n;
    e = q.pop_front();
    n = nq.pop_front();
    tests += 4;
    if (core_state !== e.st) begin
      fails++;
      $display("FAIL %s core_state got %0d want %0d", n, core_state, e.st);
    end
    if (current_pc !== e.pc) begin
      fails++;
      $display("FAIL %s current_pc got %02h want %02h", n, current_pc, e.pc);
    end
    if (done !== e.dn) begin
      fails++;
      $display("FAIL %s done got %b want %b", n, done, e.dn);
    end
    if (instr_req !== e.rq) begin
      fails++;
      $display("FAIL %s instr_req got %b want %b", n, instr_req, e.rq);
    end
  endtask
  task automatic cyc(input logic r, s, input logic [2:0] tc, input logic iv, rt,
                     input logic [3:0] b, input logic [7:0] np,
                     input logic [2:0] es, input logic [7:0] ep, input logic ed, input string nm);
    @(negedge clk);
    reset = r; start = s; thread_count = tc; instr_valid = iv;
    decoded_ret = rt; lsu_busy = b; next_pc = np;
    q.push_back('{es, ep, ed, es == 3'd1});
    nq.push_back(nm);
    @(posedge clk);
    #1 check();
  endtask
  initial begin
    reset = 1'b1; start = 1'b0; thread_count = 3'd0; instr_valid = 1'b0;
    decoded_ret = 1'b0; lsu_busy = 4'h0; next_pc = 8'h00;
    tbl = '{
      '{1'b0,1'b1,3'd4,1'b0,1'b0,4'h0,8'h00,3'd1,8'h00,1'b0},
      '{1'b0,1'b0,3'd0,1'b1,1'b0,4'h0,8'h00,3'd2,8'h00,1'b0},
      '{1'b0,1'b0,3'd0,1'b0,1'b0,4'h0,8'h00,3'd3,8'h00,1'b0},
      '{1'b0,1'b0,3'd0,1'b0,1'b0,4'h1,8'h00,3'd4,8'h00,1'b0},
      '{1'b0,1'b0,3'd0,1'b0,1'b0,4'h1,8'h00,3'd4,8'h00,1'b0},
      '{1'b1,1'b0,3'd0,1'b0,1'b0,4'h1,8'h00,3'd0,8'h00,1'b0},
      '{1'b0,1'b1,3'd0,1'b0,1'b0,4'h0,8'h00,3'd7,8'h00,1'b1},
      '{1'b0,1'b1,3'd4,1'b0,1'b0,4'h0,8'h00,3'd7,8'h00,1'b1},
      '{1'b0,1'b0,3'd0,1'b0,1'b0,4'h0,8'h00,3'd7,8'h00,1'b1},
      '{1'b1,1'b1,3'd4,1'b0,1'b0,4'h0,8'h00,3'd0,8'h00,1'b0},
      '{1'b0,1'b0,3'd0,1'b0,1'b0,4'h0,8'h00,3'd0,8'h00,1'b0},
      '{1'b0,1'b1,3'd2,1'b0,1'b0,4'h0,8'h00,3'd1,8'h00,1'b0},
      '{1'b0,1'b0,3'd0,1'b1,1'b0,4'h0,8'h00,3'd2,8'h00,1'b0},
      '{1'b0,1'b0,3'd0,1'b0,1'b0,4'h0,8'h00,3'd3,8'h00,1'b0},
      '{1'b0,1'b0,3'd0,1'b0,1'b0,4'hC,8'h00,3'd4,8'h00,1'b0},
      '{1'b0,1'b0,3'd0,1'b0,1'b0,4'hC,8'h00,3'd5,8'h00,1'b0},
      '{1'b0,1'b0,3'd0,1'b0,1'b0,4'h0,8'h00,3'd6,8'h00,1'b0},
      '{1'b0,1'b0,3'd0,1'b0,1'b0,4'h0,8'h10,3'd1,8'h10,1'b0},
      '{1'b0,1'b0,3'd0,1'b1,1'b0,4'h0,8'h00,3'd2,8'h10,1'b0},
      '{1'b0,1'b0,3'd0,1'b0,1'b0,4'h0,8'h00,3'd3,8'h10,1'b0},
      '{1'b0,1'b0,3'd0,1'b0,1'b0,4'h2,8'h00,3'd4,8'h10,1'b0},
      '{1'b0,1'b0,3'd0,1'b0,1'b0,4'h2,8'h00,3'd4,8'h10,1'b0},
      '{1'b0,1'b0,3'd0,1'b0,1'b0,4'h2,8'h00,3'd4,8'h10,1'b0},
      '{1'b0,1'b0,3'd0,1'b0,1'b0,4'h0,8'h00,3'd5,8'h10,1'b0},
      '{1'b0,1'b0,3'd0,1'b0,1'b0,4'h0,8'h00,3'd6,8'h10,1'b0},
      '{1'b0,1'b0,3'd0,1'b0,1'b1,4'h0,8'h55,3'd7,8'h10,1'b1},
      '{1'b0,1'b1,3'd4,1'b0,1'b0,4'h0,8'h00,3'd7,8'h10,1'b1},
      '{1'b1,1'b0,3'd0,1'b0,1'b0,4'h0,8'h00,3'd0,8'h00,1'b0}
    };
    cyc(1,0,0,0,0,4'h0,8'h00, 3'd0,8'h00,0, "reset");
    for (int i = 0; i < 28; i++)
      cyc(tbl[i].r, tbl[i].s, tbl[i].tc, tbl[i].iv, tbl[i].rt, tbl[i].b, tbl[i].np,
          tbl[i].es, tbl[i].ep, tbl[i].ed, $sformatf("vec%0d", i));
    // Three back-to-back minimum-latency instructions, RET on the third.
    cyc(0,1,4,0,0,4'h0,8'h00, 3'd1,8'h00,0, "ret_start");
    for (int n = 1; n <= 18; n++)
      cyc(0,0,0,1,((n-1)/6) == 2,4'h0,8'((n-1)/6 + 1),
          n == 18 ? 3'd7 : 3'(n % 6 + 1), n == 18 ? 8'h02 : 8'(n / 6), n == 18,
          $sformatf("ret_seq%0d", n));
    cyc(1,0,0,0,0,4'h0,8'h00, 3'd0,8'h00,0, "ret_reset");
    cyc(0,1,1,0,0,4'h0,8'h00, 3'd1,8'h00,0, "stall_start");
    for (int n = 0; n < 5; n++)
      cyc(0,0,0,0,0,4'h0,8'h00, 3'd1,8'h00,0, $sformatf("fetch_stall%0d", n));
    cyc(0,0,0,1,0,4'h0,8'h00, 3'd2,8'h00,0, "stall_decode");
    cyc(0,0,0,0,0,4'h0,8'h00, 3'd3,8'h00,0, "stall_request");
    cyc(0,0,0,0,0,4'hE,8'h00, 3'd4,8'h00,0, "inactive_wait");
    cyc(0,0,0,0,0,4'hE,8'h00, 3'd5,8'h00,0, "inactive_ignored");
    cyc(0,0,0,0,0,4'h0,8'h00, 3'd6,8'h00,0, "to_update");
    cyc(0,0,0,0,0,4'h0,8'hFF, 3'd1,8'hFF,0, "pc_ff");
    cyc(0,0,0,1,0,4'h0,8'h00, 3'd2,8'hFF,0, "wrap_decode");
    cyc(0,0,0,0,0,4'h0,8'h00, 3'd3,8'hFF,0, "wrap_request");
    cyc(0,0,0,0,0,4'h0,8'h00, 3'd4,8'hFF,0, "wrap_wait");
    cyc(0,0,0,0,0,4'h0,8'h00, 3'd5,8'hFF,0, "wrap_execute");
    cyc(0,0,0,0,0,4'h0,8'h00, 3'd6,8'hFF,0, "wrap_update");
    cyc(0,0,0,0,0,4'h0,8'h00, 3'd1,8'h00,0, "pc_wrap");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
